// File: rtl/chacha20_block_sched.sv
// ChaCha20 block scheduler: builds the core's initial state, launches one block at a time,
// and streams keystream blocks downstream. Optional macro: CHACHA_CTR_WRAP_CHK_EN.
module chacha20_block_sched #(
  parameter int MAX_BLOCKS_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [255:0]            key,
  input  logic [95:0]             nonce,
  input  logic [31:0]             ctr_init,
  input  logic [MAX_BLOCKS_W-1:0] num_blocks,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [511:0]            core_state,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [511:0]            core_block,
  output logic [511:0]            ks_block,
  output logic                    ks_valid,
  input  logic                    ks_ready,
  output logic [31:0]             ks_ctr
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EMIT} state_t;

  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  state_t                  state_q, state_d;
  logic [255:0]            key_q, key_d;
  logic [95:0]             nonce_q, nonce_d;
  logic [31:0]             ctr_q, ctr_d;
  logic [MAX_BLOCKS_W-1:0] rem_q, rem_d;
  logic [511:0]            ks_block_q, ks_block_d;
  logic [31:0]             ks_ctr_q, ks_ctr_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    loaded_q, loaded_d;
  logic                    wrap_rej;

`ifdef CHACHA_CTR_WRAP_CHK_EN
  // Reject jobs whose last block counter would not fit in 32 bits.
  logic [32:0] last_ctr;
  assign last_ctr = {1'b0, ctr_init} + 33'(num_blocks) - 33'd1;
  assign wrap_rej = last_ctr[32];
`else
  assign wrap_rej = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    ks_block_d = ks_block_q;
    ks_ctr_d   = ks_ctr_q;
    loaded_d   = loaded_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_blocks == '0) begin
            done_d = 1'b1;
          end else if (wrap_rej) begin
            err_d = 1'b1;
          end else begin
            key_d    = key;
            nonce_d  = nonce;
            ctr_d    = ctr_init;
            rem_d    = num_blocks;
            loaded_d = 1'b1;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (core_done) begin
          ks_block_d = core_block;
          ks_ctr_d   = ctr_q;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ks_ready) begin
          // A block handed over in the abort cycle still counts as delivered.
          ctr_d = ctr_q + 32'd1;
          rem_d = rem_q - MAX_BLOCKS_W'(1);
          if (abort) begin
            state_d = S_IDLE;
          end else if (rem_q == MAX_BLOCKS_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LAUNCH;
          end
        end else if (abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      nonce_q    <= '0;
      ctr_q      <= '0;
      rem_q      <= '0;
      ks_block_q <= '0;
      ks_ctr_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      rem_q      <= rem_d;
      ks_block_q <= ks_block_d;
      ks_ctr_q   <= ks_ctr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      loaded_q   <= loaded_d;
    end
  end

  // State image stays all-zero until the first accepted job.
  assign core_state = loaded_q ? {nonce_q, ctr_q, key_q, SIGMA} : '0;
  assign core_start = (state_q == S_LAUNCH) && !abort;
  assign busy       = (state_q != S_IDLE);
  assign ks_valid   = (state_q == S_EMIT);
  assign ks_block   = ks_block_q;
  assign ks_ctr     = ks_ctr_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
